apb_bus1_master: RTL and testbench
==================================

Name: apb_bus1_master

Overview:
- Single-initiator APB master and address decoder for peripheral Bus[1] (UART1, PRCI, DMI, I2C0, GPIO, DDR mgmt, PCIE, PnP).
- Accepts a simple 64-bit request/response transaction, decodes it against CFG_BUS1_MAP, and issues one or two 32-bit APB transfers to the selected slave.
- Returns read data or an error response.
- Sits between the system-bus bridge and the Bus[1] APB slave vectors.

Parameters:
- timeout_cycles, 1023: ACCESS-phase cycles without pready before the transfer is aborted with error.

Ports:
- i_clk  in  1  clock
- i_nrst  in  1  reset; one clock, asynchronous, active-low
- i_req_valid  in  1  request valid
- o_req_ready  out  1  request accepted when valid&ready
- i_req_addr  in  48  byte address, Bus[1]-relative
- i_req_size  in  2  2 = 4-byte, 3 = 8-byte; other codes are treated as 3
- i_req_write  in  1  1 = write
- i_req_wdata  in  64  write data, lane-aligned by addr[2]
- i_req_wstrb  in  8  write byte strobes
- o_resp_valid  out  1  response valid
- i_resp_ready  in  1  response consumed
- o_resp_rdata  out  64  read data
- o_resp_err  out  1  decode, slave, or timeout error
- o_apbo  out  bus1_apb_in_vector  per-slave APB request (paddr, pprot, pselx, penable, pwrite, pwdata, pstrb)
- i_apbi  in  bus1_apb_out_vector  per-slave APB response (prdata, pready, pslverr)

Behaviour:
- Reset values:
  - all o_apbo fields 0
  - o_req_ready = 1
  - o_resp_valid = 0, o_resp_err = 0, o_resp_rdata = 0
  - state IDLE, timeout counter 0
- Reset asserted mid-transfer drops pselx/penable in the same instant (asynchronous) and discards the pending transaction; no response is produced.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - o_req_ready = 1.
  - On valid&ready, latch addr, size, write, wdata, wstrb.
  - Decode: idx = lowest i with CFG_BUS1_MAP[i].addr_start <= addr < addr_end; comparison uses the zero-extended 64-bit address.
  - Beat plan:
    - size 2: one beat, half = addr[2].
    - size 3: low beat then high beat.
    - Write with size 3: a beat whose 4-bit strobe is zero is skipped. If both are zero, no APB beats run (err = 0).
  - No map hit: go to RESP with err = 1 and rdata = all-ones, no APB activity.
  - Hit: go to SETUP; rdata accumulator cleared.
- SETUP (1 cycle):
  - pselx = 1 on slave idx only; penable = 0.
  - paddr = {addr[31:3], half, 2'b00}; pwrite = latched write; pprot = 0.
  - pwdata = wdata[32*half+:32]; pstrb = wstrb[4*half+:4] for writes, 0 for reads.
  - Next state: ACCESS.
- ACCESS:
  - penable = 1; all other APB fields are held.
  - Timeout counter increments each cycle pready = 0.
  - pready = 1: rdata[32*half+:32] <= prdata (reads only); err |= pslverr; counter cleared; psel/penable drop next cycle. Next state is SETUP for the remaining beat, else RESP.
  - Counter == timeout_cycles with pready still 0: deassert psel/penable, set err = 1, skip any remaining beat, go to RESP.
- RESP:
  - o_resp_valid = 1; rdata and err are stable until i_resp_ready.
  - Return to IDLE in the cycle after the handshake; o_req_ready = 0 in every state except IDLE.
- Latency, zero-wait slave:
  - 1-beat request: accepted cycle T, SETUP T+1, ACCESS T+2, resp_valid T+3.
  - 2-beat request: resp_valid T+5.
- The slave sees a pready = 1 beat exactly once; a pslverr on the first beat still executes the second beat.
- Inputs are ignored outside IDLE; i_apbi of unselected slaves is ignored.

Decomposition:
- Shared package apb_bus1_master_pkg: state encoding, beat-plan constants, and the timeout counter width ($clog2(timeout_cycles + 1)).
- Sub-module apb_bus1_decoder: combinational CFG_BUS1_MAP lookup giving hit plus a CFG_BUS1_PSLV_LOG2_TOTAL-bit index.
- All FSM and datapath logic stays in apb_bus1_master.

Test Plan:
- 4-byte write addr 0x12004, wdata 0xDEADBEEF_00000000, wstrb 0xF0 -> only pselx[PRCI]; paddr 0x12004, pwdata 0xDEADBEEF, pstrb 0xF; resp err = 0 at T+3.
- 8-byte read addr 0xFF000; PnP returns 0x11111111 then 0x22222222 -> two SETUP/ACCESS pairs at paddr 0xFF000 and 0xFF004; rdata 0x22222222_11111111, err = 0.
- Read addr 0x30000 (unmapped) -> no pselx asserted; resp rdata 0xFFFFFFFF_FFFFFFFF, err = 1.
- GPIO holds pready = 0 -> abort after 1023 ACCESS cycles; psel drops; err = 1; second beat not issued.
- 8-byte write to UART1 with pslverr = 1 on beat 0 -> beat 1 still issued; err = 1.
- i_nrst pulsed low during ACCESS -> psel/penable 0 immediately, o_resp_valid 0, o_req_ready 1 after release.
- o_resp_valid held with i_resp_ready = 0 for 5 cycles -> data stable, new request not accepted.

Source files
------------

// File: rtl/apb_bus1_master_pkg.sv
// Shared definitions for the Bus[1] APB master.
// - Slave indices and address map of the peripheral Bus[1].
// - APB request/response structs and the per-slave vectors.
// - FSM state encoding, beat-plan constants, timeout counter sizing.
package apb_bus1_master_pkg;

  localparam int CFG_BUS1_PSLV_TOTAL      = 8;
  localparam int CFG_BUS1_PSLV_LOG2_TOTAL = 3;

  localparam int CFG_BUS1_PSLV_UART1 = 0;
  localparam int CFG_BUS1_PSLV_PRCI  = 1;
  localparam int CFG_BUS1_PSLV_DMI   = 2;
  localparam int CFG_BUS1_PSLV_I2C0  = 3;
  localparam int CFG_BUS1_PSLV_GPIO  = 4;
  localparam int CFG_BUS1_PSLV_DDR   = 5;
  localparam int CFG_BUS1_PSLV_PCIE  = 6;
  localparam int CFG_BUS1_PSLV_PNP   = 7;

  // Master -> slave
  typedef struct packed {
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } apb_in_type;

  // Slave -> master
  typedef struct packed {
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
  } apb_out_type;

  typedef apb_in_type  [CFG_BUS1_PSLV_TOTAL-1:0] bus1_apb_in_vector;
  typedef apb_out_type [CFG_BUS1_PSLV_TOTAL-1:0] bus1_apb_out_vector;

  typedef struct packed {
    logic [63:0] addr_start;
    logic [63:0] addr_end;   // exclusive
  } mapinfo_type;

  typedef mapinfo_type [CFG_BUS1_PSLV_TOTAL-1:0] bus1_mapinfo_vector;

  // Concatenation lists the highest slave index first.
  localparam bus1_mapinfo_vector CFG_BUS1_MAP = {
    mapinfo_type'({64'h0000_0000_000F_F000, 64'h0000_0000_0010_0000}),  // PNP
    mapinfo_type'({64'h0000_0000_000C_1000, 64'h0000_0000_000C_2000}),  // PCIE
    mapinfo_type'({64'h0000_0000_000C_0000, 64'h0000_0000_000C_1000}),  // DDR
    mapinfo_type'({64'h0000_0000_0006_0000, 64'h0000_0000_0006_1000}),  // GPIO
    mapinfo_type'({64'h0000_0000_0005_2000, 64'h0000_0000_0005_3000}),  // I2C0
    mapinfo_type'({64'h0000_0000_0001_E000, 64'h0000_0000_0001_F000}),  // DMI
    mapinfo_type'({64'h0000_0000_0001_2000, 64'h0000_0000_0001_3000}),  // PRCI
    mapinfo_type'({64'h0000_0000_0001_0000, 64'h0000_0000_0001_1000})   // UART1
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Beat plan
  localparam logic [1:0] REQ_SIZE_4B = 2'd2;  // any other code is an 8-byte access
  localparam logic       HALF_LO     = 1'b0;
  localparam logic       HALF_HI     = 1'b1;

  localparam int CFG_TIMEOUT_CYCLES = 1023;
  localparam int TIMEOUT_CNT_W      = $clog2(CFG_TIMEOUT_CYCLES + 1);

endpackage

// File: rtl/apb_bus1_decoder.sv
// Combinational Bus[1] address decoder.
// - i_addr : Bus[1]-relative byte address (zero-extended to 64 bits for compare)
// - o_hit  : address falls inside one of the map windows
// - o_idx  : lowest matching slave index (valid when o_hit)
module apb_bus1_decoder
  import apb_bus1_master_pkg::*;
(
  input  logic [47:0]                         i_addr,
  output logic                                o_hit,
  output logic [CFG_BUS1_PSLV_LOG2_TOTAL-1:0] o_idx
);

  logic [63:0] addr64;
  assign addr64 = {16'h0000, i_addr};

  // Walk downward so the lowest matching index is the one left standing.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = CFG_BUS1_PSLV_TOTAL - 1; i >= 0; i--) begin
      if (addr64 >= CFG_BUS1_MAP[i].addr_start && addr64 < CFG_BUS1_MAP[i].addr_end) begin
        o_hit = 1'b1;
        o_idx = CFG_BUS1_PSLV_LOG2_TOTAL'(i);
      end
    end
  end

endmodule

// File: rtl/apb_bus1_master.sv
// Single-initiator APB master for peripheral Bus[1].
// Takes a 64-bit request, decodes it, runs one or two 32-bit APB beats on the
// selected slave and returns read data / error.
// - i_clk, i_nrst        : clock, async active-low reset
// - i_req_* / o_req_ready: request channel (accepted only in IDLE)
// - o_resp_* / i_resp_ready: response channel, held until consumed
// - o_apbo / i_apbi      : per-slave APB request / response vectors
module apb_bus1_master
  import apb_bus1_master_pkg::*;
#(
  parameter int timeout_cycles = CFG_TIMEOUT_CYCLES
) (
  input  logic               i_clk,
  input  logic               i_nrst,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [47:0]        i_req_addr,
  input  logic [1:0]         i_req_size,
  input  logic               i_req_write,
  input  logic [63:0]        i_req_wdata,
  input  logic [7:0]         i_req_wstrb,
  output logic               o_resp_valid,
  input  logic               i_resp_ready,
  output logic [63:0]        o_resp_rdata,
  output logic               o_resp_err,
  output bus1_apb_in_vector  o_apbo,
  input  bus1_apb_out_vector i_apbi
);

  localparam int CNT_W = $clog2(timeout_cycles + 1);
  localparam int IDX_W = CFG_BUS1_PSLV_LOG2_TOTAL;

  state_e             state_q;
  logic               req_ready_q;
  logic               resp_valid_q;
  logic [63:0]        rdata_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic               half_q;
  logic               second_q;    // high beat still to run
  logic               write_q;
  logic [31:0]        wdata_hi_q;
  logic [3:0]         wstrb_hi_q;
  // Shared APB request registers; pselx/penable are steered per slave below.
  logic [31:0]        paddr_q;
  logic               pwrite_q;
  logic [31:0]        pwdata_q;
  logic [3:0]         pstrb_q;
  logic               psel_q;
  logic               penable_q;

  logic               dec_hit;
  logic [IDX_W-1:0]   dec_idx;

  apb_bus1_decoder u_dec (
    .i_addr (i_req_addr),
    .o_hit  (dec_hit),
    .o_idx  (dec_idx)
  );

  // Beat plan of the incoming request. Writes of 8 bytes skip any half whose
  // strobes are all zero; reads always run both halves.
  logic first_en, first_half, second_en, lo_en, hi_en;
  always_comb begin
    lo_en = !i_req_write || (|i_req_wstrb[3:0]);
    hi_en = !i_req_write || (|i_req_wstrb[7:4]);
    if (i_req_size == REQ_SIZE_4B) begin
      first_en   = 1'b1;
      first_half = i_req_addr[2];
      second_en  = 1'b0;
    end else begin
      first_en   = lo_en || hi_en;
      first_half = lo_en ? HALF_LO : HALF_HI;
      second_en  = lo_en && hi_en;
    end
  end

  // Only the selected slave's response is looked at.
  apb_out_type sel_rsp;
  assign sel_rsp = i_apbi[idx_q];

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      idx_q        <= '0;
      half_q       <= 1'b0;
      second_q     <= 1'b0;
      write_q      <= 1'b0;
      wdata_hi_q   <= '0;
      wstrb_hi_q   <= '0;
      paddr_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            write_q     <= i_req_write;
            wdata_hi_q  <= i_req_wdata[63:32];
            wstrb_hi_q  <= i_req_wstrb[7:4];
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            if (!dec_hit) begin
              rdata_q      <= '1;
              err_q        <= 1'b1;
              resp_valid_q <= 1'b1;
              state_q      <= ST_RESP;
            end else if (!first_en) begin
              // 8-byte write with no strobes: nothing to send
              resp_valid_q <= 1'b1;
              state_q      <= ST_RESP;
            end else begin
              idx_q     <= dec_idx;
              half_q    <= first_half;
              second_q  <= second_en;
              paddr_q   <= {i_req_addr[31:3], first_half, 2'b00};
              pwrite_q  <= i_req_write;
              pwdata_q  <= first_half ? i_req_wdata[63:32] : i_req_wdata[31:0];
              pstrb_q   <= !i_req_write ? 4'h0 :
                           (first_half ? i_req_wstrb[7:4] : i_req_wstrb[3:0]);
              psel_q    <= 1'b1;
              penable_q <= 1'b0;
              state_q   <= ST_SETUP;
            end
          end
        end

        ST_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (sel_rsp.pready) begin
            if (!write_q) begin
              if (half_q) rdata_q[63:32] <= sel_rsp.prdata;
              else        rdata_q[31:0]  <= sel_rsp.prdata;
            end
            err_q     <= err_q | sel_rsp.pslverr;
            cnt_q     <= '0;
            penable_q <= 1'b0;
            if (second_q) begin
              // Back-to-back high beat: psel stays up, new SETUP phase.
              second_q   <= 1'b0;
              half_q     <= HALF_HI;
              paddr_q[2] <= HALF_HI;
              pwdata_q   <= wdata_hi_q;
              pstrb_q    <= write_q ? wstrb_hi_q : 4'h0;
              state_q    <= ST_SETUP;
            end else begin
              psel_q       <= 1'b0;
              resp_valid_q <= 1'b1;
              state_q      <= ST_RESP;
            end
          end else if (cnt_q == CNT_W'(timeout_cycles)) begin
            // Abort: any remaining beat is dropped.
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            second_q     <= 1'b0;
            err_q        <= 1'b1;
            cnt_q        <= '0;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_RESP: begin
          if (i_resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_req_ready  = req_ready_q;
  assign o_resp_valid = resp_valid_q;
  assign o_resp_rdata = rdata_q;
  assign o_resp_err   = err_q;

  for (genvar g = 0; g < CFG_BUS1_PSLV_TOTAL; g++) begin : g_apbo
    logic hit;
    assign hit = (idx_q == IDX_W'(g));
    assign o_apbo[g] = '{paddr:   paddr_q,
                         pprot:   3'b000,
                         pselx:   psel_q && hit,
                         penable: penable_q && hit,
                         pwrite:  pwrite_q,
                         pwdata:  pwdata_q,
                         pstrb:   pstrb_q};
  end

endmodule

// File: tb/tb_apb_bus1_master.sv
module tb_apb_bus1_master;
  import apb_bus1_master_pkg::*;

  logic               i_clk = 1'b0;
  logic               i_nrst = 1'b0;
  logic               i_req_valid = 1'b0;
  logic               o_req_ready;
  logic [47:0]        i_req_addr = '0;
  logic [1:0]         i_req_size = '0;
  logic               i_req_write = 1'b0;
  logic [63:0]        i_req_wdata = '0;
  logic [7:0]         i_req_wstrb = '0;
  logic               o_resp_valid;
  logic               i_resp_ready = 1'b0;
  logic [63:0]        o_resp_rdata;
  logic               o_resp_err;
  bus1_apb_in_vector  o_apbo;
  bus1_apb_out_vector i_apbi;

  int checks = 0;
  int errors = 0;

  // Slave model: every slave answers alike; data/error depend on the half addressed.
  logic        slv_pready = 1'b1;
  logic [31:0] rd_lo = 32'h1111_1111;
  logic [31:0] rd_hi = 32'h2222_2222;
  logic        err_lo = 1'b0;
  logic        err_hi = 1'b0;

  always_comb begin
    i_apbi = '0;
    for (int i = 0; i < CFG_BUS1_PSLV_TOTAL; i++) begin
      i_apbi[i].prdata  = o_apbo[i].paddr[2] ? rd_hi : rd_lo;
      i_apbi[i].pready  = slv_pready;
      i_apbi[i].pslverr = o_apbo[i].paddr[2] ? err_hi : err_lo;
    end
  end

  apb_bus1_master dut (
    .i_clk        (i_clk),
    .i_nrst       (i_nrst),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_addr   (i_req_addr),
    .i_req_size   (i_req_size),
    .i_req_write  (i_req_write),
    .i_req_wdata  (i_req_wdata),
    .i_req_wstrb  (i_req_wstrb),
    .o_resp_valid (o_resp_valid),
    .i_resp_ready (i_resp_ready),
    .o_resp_rdata (o_resp_rdata),
    .o_resp_err   (o_resp_err),
    .o_apbo       (o_apbo),
    .i_apbi       (i_apbi)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] psel_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = o_apbo[i].pselx;
    return v;
  endfunction

  function automatic logic [7:0] pen_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = o_apbo[i].penable;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Presents one request in cycle T and returns at T+1.
  task automatic send(input logic [47:0] a, input logic [1:0] sz, input logic wr,
                      input logic [63:0] wd, input logic [7:0] ws);
    i_req_addr  = a;
    i_req_size  = sz;
    i_req_write = wr;
    i_req_wdata = wd;
    i_req_wstrb = ws;
    i_req_valid = 1'b1;
    chk("req_ready_idle", o_req_ready, 1);
    step();
    i_req_valid = 1'b0;
  endtask

  task automatic consume();
    i_resp_ready = 1'b1;
    step();
    i_resp_ready = 1'b0;
    chk("resp_valid_drop", o_resp_valid, 0);
    chk("req_ready_back", o_req_ready, 1);
  endtask

  initial begin
    int n;
    // ---- reset state
    step(2);
    chk("rst_req_ready", o_req_ready, 1);
    chk("rst_resp_valid", o_resp_valid, 0);
    chk("rst_resp_err", o_resp_err, 0);
    chk("rst_resp_rdata", o_resp_rdata, 64'h0);
    chk("rst_apbo_zero", (o_apbo == '0), 1);
    i_nrst = 1'b1;
    step();

    // ---- 4-byte write, high half, PRCI
    send(48'h12004, 2'd2, 1'b1, 64'hDEADBEEF_00000000, 8'hF0);
    chk("w4_psel", psel_vec(), 8'h02);
    chk("w4_penable_setup", pen_vec(), 8'h00);
    chk("w4_paddr", o_apbo[CFG_BUS1_PSLV_PRCI].paddr, 32'h12004);
    chk("w4_pwdata", o_apbo[CFG_BUS1_PSLV_PRCI].pwdata, 32'hDEADBEEF);
    chk("w4_pstrb", o_apbo[CFG_BUS1_PSLV_PRCI].pstrb, 4'hF);
    chk("w4_pwrite", o_apbo[CFG_BUS1_PSLV_PRCI].pwrite, 1);
    step();
    chk("w4_penable_access", pen_vec(), 8'h02);
    chk("w4_resp_early", o_resp_valid, 0);
    step();
    chk("w4_resp_valid_T3", o_resp_valid, 1);
    chk("w4_resp_err", o_resp_err, 0);
    chk("w4_req_ready_busy", o_req_ready, 0);
    chk("w4_psel_drop", psel_vec(), 8'h00);
    consume();

    // ---- 8-byte read, PnP, two beats
    send(48'hFF000, 2'd3, 1'b0, 64'h0, 8'h00);
    chk("r8_psel_b0", psel_vec(), 8'h80);
    chk("r8_paddr_b0", o_apbo[CFG_BUS1_PSLV_PNP].paddr, 32'hFF000);
    chk("r8_pstrb_rd", o_apbo[CFG_BUS1_PSLV_PNP].pstrb, 4'h0);
    chk("r8_pwrite", o_apbo[CFG_BUS1_PSLV_PNP].pwrite, 0);
    step();
    chk("r8_pen_b0", pen_vec(), 8'h80);
    step();
    chk("r8_psel_b1", psel_vec(), 8'h80);
    chk("r8_pen_setup_b1", pen_vec(), 8'h00);
    chk("r8_paddr_b1", o_apbo[CFG_BUS1_PSLV_PNP].paddr, 32'hFF004);
    step();
    chk("r8_pen_b1", pen_vec(), 8'h80);
    step();
    chk("r8_resp_valid_T5", o_resp_valid, 1);
    chk("r8_rdata", o_resp_rdata, 64'h22222222_11111111);
    chk("r8_err", o_resp_err, 0);
    consume();

    // ---- 4-byte read of high half: data lands in upper lane
    send(48'hFF004, 2'd2, 1'b0, 64'h0, 8'h00);
    chk("r4hi_paddr", o_apbo[CFG_BUS1_PSLV_PNP].paddr, 32'hFF004);
    step(2);
    chk("r4hi_rdata", o_resp_rdata, 64'h22222222_00000000);
    consume();

    // ---- unmapped read, then response held with a new request pending
    send(48'h30000, 2'd3, 1'b0, 64'h0, 8'h00);
    chk("miss_psel", psel_vec(), 8'h00);
    chk("miss_resp_valid", o_resp_valid, 1);
    chk("miss_rdata", o_resp_rdata, 64'hFFFFFFFF_FFFFFFFF);
    chk("miss_err", o_resp_err, 1);
    i_req_addr  = 48'h12000;
    i_req_size  = 2'd2;
    i_req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("hold_req_ready", o_req_ready, 0);
      chk("hold_resp_valid", o_resp_valid, 1);
      chk("hold_rdata", o_resp_rdata, 64'hFFFFFFFF_FFFFFFFF);
      chk("hold_err", o_resp_err, 1);
      chk("hold_no_psel", psel_vec(), 8'h00);
    end
    i_req_valid = 1'b0;
    consume();

    // ---- 8-byte write to UART1, slave error on beat 0
    err_lo = 1'b1;
    send(48'h10000, 2'd3, 1'b1, 64'hAAAAAAAA_55555555, 8'hFF);
    chk("slverr_psel_b0", psel_vec(), 8'h01);
    chk("slverr_pwdata_b0", o_apbo[CFG_BUS1_PSLV_UART1].pwdata, 32'h55555555);
    chk("slverr_pstrb_b0", o_apbo[CFG_BUS1_PSLV_UART1].pstrb, 4'hF);
    step(2);
    chk("slverr_psel_b1", psel_vec(), 8'h01);
    chk("slverr_paddr_b1", o_apbo[CFG_BUS1_PSLV_UART1].paddr, 32'h10004);
    chk("slverr_pwdata_b1", o_apbo[CFG_BUS1_PSLV_UART1].pwdata, 32'hAAAAAAAA);
    step(2);
    chk("slverr_resp_valid", o_resp_valid, 1);
    chk("slverr_err", o_resp_err, 1);
    consume();
    err_lo = 1'b0;

    // ---- strobe-driven beat skipping on GPIO
    send(48'h60000, 2'd3, 1'b1, 64'h87654321_12345678, 8'h0F);
    chk("lo_only_paddr", o_apbo[CFG_BUS1_PSLV_GPIO].paddr, 32'h60000);
    chk("lo_only_psel", psel_vec(), 8'h10);
    step(2);
    chk("lo_only_resp_T3", o_resp_valid, 1);
    consume();
    send(48'h60000, 2'd3, 1'b1, 64'h87654321_12345678, 8'hF0);
    chk("hi_only_paddr", o_apbo[CFG_BUS1_PSLV_GPIO].paddr, 32'h60004);
    chk("hi_only_pwdata", o_apbo[CFG_BUS1_PSLV_GPIO].pwdata, 32'h87654321);
    step(2);
    chk("hi_only_resp_T3", o_resp_valid, 1);
    consume();
    send(48'h60000, 2'd3, 1'b1, 64'h87654321_12345678, 8'h00);
    chk("nostrb_psel", psel_vec(), 8'h00);
    chk("nostrb_resp", o_resp_valid, 1);
    chk("nostrb_err", o_resp_err, 0);
    consume();

    // ---- GPIO never ready: timeout abort, high beat not issued
    slv_pready = 1'b0;
    send(48'h60000, 2'd3, 1'b0, 64'h0, 8'h00);
    chk("to_psel", psel_vec(), 8'h10);
    n = 0;
    step();
    while (psel_vec() != 8'h00 && n < 1100) begin
      if (pen_vec() == 8'h10) n++;
      step();
    end
    chk("to_access_cycles_1023_1024", (n == 1023 || n == 1024), 1);
    chk("to_resp_valid", o_resp_valid, 1);
    chk("to_err", o_resp_err, 1);
    step(2);
    chk("to_no_second_beat", psel_vec(), 8'h00);
    consume();

    // ---- reset pulse during ACCESS
    send(48'h12000, 2'd2, 1'b0, 64'h0, 8'h00);
    step();
    chk("rst_mid_pen", pen_vec(), 8'h02);
    #2 i_nrst = 1'b0;
    #1;
    chk("rst_mid_psel_drop", psel_vec(), 8'h00);
    chk("rst_mid_pen_drop", pen_vec(), 8'h00);
    chk("rst_mid_resp_valid", o_resp_valid, 0);
    step();
    i_nrst = 1'b1;
    slv_pready = 1'b1;
    step(2);
    chk("rst_rel_req_ready", o_req_ready, 1);
    chk("rst_rel_resp_valid", o_resp_valid, 0);
    chk("rst_rel_psel", psel_vec(), 8'h00);

    // ---- recovery transaction
    send(48'h12000, 2'd2, 1'b0, 64'h0, 8'h00);
    chk("rec_psel", psel_vec(), 8'h02);
    step(2);
    chk("rec_resp_valid", o_resp_valid, 1);
    chk("rec_rdata", o_resp_rdata, 64'h00000000_11111111);
    consume();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
